// File: rtl/avmm_pkg.sv
// Shared types and helpers for the Avalon-MM memory responder:
// FSM state encoding, LFSR constants and the byte-address to word-index mapping.
package avmm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (maximal length)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                               input int unsigned depth_log2);
        logic [31:0] mask;
        mask = (32'd1 << depth_log2) - 32'd1;
        return (byte_addr >> 2) & mask;
    endfunction

endpackage

// File: rtl/avmm_sp_ram.sv
// Byte-enabled single-port RAM with a registered read port; contents are never reset.
module avmm_sp_ram #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    output logic [DATA_W-1:0]     q
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    // A same-address write returns the old word; the parent never relies on that case.
    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_W/8; b++) begin
            if (we && be[b]) begin
                mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/avmm_mem_slave.sv
// Avalon-MM pipelined burst memory responder with fixed read latency.
// Optional macro AVS_RANDOM_WAIT_EN adds LFSR-driven random waitrequest in IDLE/WR_BURST.
module avmm_mem_slave
    import avmm_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 20,
    parameter int DEPTH_LOG2   = 10,
    parameter int BURST_W      = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [DATA_W-1:0]   avs_writedata,
    input  logic [DATA_W/8-1:0] avs_byteenable,
    input  logic [BURST_W-1:0]  avs_burstcount,
    output logic                avs_waitrequest,
    output logic [DATA_W-1:0]   avs_readdata,
    output logic                avs_readdatavalid,
    output logic                busy,
    output logic                err_sticky
);

    state_t                state, state_next;
    logic [DEPTH_LOG2-1:0] ptr, ptr_next, cmd_idx, ram_addr;
    logic [BURST_W-1:0]    remaining, remaining_next, first_count;
    logic                  err_next, ram_we, issue, forced_wait, pipe_busy;
    logic [DATA_W-1:0]     ram_q;

    assign cmd_idx     = DEPTH_LOG2'(word_index(32'(avs_address), DEPTH_LOG2));
    assign first_count = (avs_burstcount == '0) ? BURST_W'(1) : avs_burstcount;

`ifdef AVS_RANDOM_WAIT_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
        end
    end

    assign forced_wait = (state != RD_BURST) && (lfsr[1:0] == 2'b00);
`else
    assign forced_wait = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= '0;
            remaining  <= '0;
            err_sticky <= 1'b0;
        end else begin
            state      <= state_next;
            ptr        <= ptr_next;
            remaining  <= remaining_next;
            err_sticky <= err_next;
        end
    end

    // ptr always names the next word to touch; in IDLE the RAM is addressed straight
    // from the bus so beat 0 of a read is fetched in its accept cycle.
    always_comb begin
        state_next     = state;
        ptr_next       = ptr;
        remaining_next = remaining;
        err_next       = err_sticky;
        ram_we         = 1'b0;
        ram_addr       = ptr;
        issue          = 1'b0;
        case (state)
            IDLE: begin
                ram_addr = cmd_idx;
                if (!forced_wait) begin
                    if (avs_write) begin
                        ram_we         = 1'b1;
                        ptr_next       = cmd_idx + DEPTH_LOG2'(1);
                        remaining_next = first_count - BURST_W'(1);
                        if (avs_read) err_next = 1'b1;
                        if (first_count != BURST_W'(1)) state_next = WR_BURST;
                    end else if (avs_read) begin
                        ptr_next       = cmd_idx + DEPTH_LOG2'(1);
                        remaining_next = first_count;
                        state_next     = RD_BURST;
                    end
                end
            end
            WR_BURST: begin
                if (!forced_wait) begin
                    if (avs_write) begin
                        ram_we         = 1'b1;
                        ptr_next       = ptr + DEPTH_LOG2'(1);
                        remaining_next = remaining - BURST_W'(1);
                        if (remaining == BURST_W'(1)) state_next = IDLE;
                    end
                    if (avs_read) err_next = 1'b1;
                end
            end
            RD_BURST: begin
                issue          = 1'b1;
                ptr_next       = ptr + DEPTH_LOG2'(1);
                remaining_next = remaining - BURST_W'(1);
                if (remaining == BURST_W'(1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    avmm_sp_ram #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (avs_writedata),
        .be    (avs_byteenable),
        .q     (ram_q)
    );

    // The RAM register supplies the first cycle of latency; the rest is a plain shift pipe.
    if (READ_LATENCY == 1) begin : g_direct
        assign avs_readdatavalid = issue && reset_n;
        assign avs_readdata      = avs_readdatavalid ? ram_q : '0;
        assign pipe_busy         = 1'b0;
    end else begin : g_pipe
        localparam int STAGES = READ_LATENCY - 1;
        logic [STAGES-1:0] vld;
        logic [DATA_W-1:0] dat [STAGES];

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                vld <= '0;
                for (int i = 0; i < STAGES; i++) dat[i] <= '0;
            end else begin
                vld[0] <= issue;
                dat[0] <= ram_q;
                for (int i = 1; i < STAGES; i++) begin
                    vld[i] <= vld[i-1];
                    dat[i] <= dat[i-1];
                end
            end
        end

        assign avs_readdatavalid = vld[STAGES-1];
        assign avs_readdata      = dat[STAGES-1];
        assign pipe_busy         = |vld;
    end

    assign avs_waitrequest = !reset_n || (state == RD_BURST) || forced_wait;
    assign busy            = (state != IDLE) || pipe_busy;

endmodule

// File: doc/avmm_mem_slave.md
Name: avmm_mem_slave

Overview:
- Avalon-MM pipelined, burst-capable memory responder. It is the slave end that the bus_sys read/write master pair talks to in simulation and on-chip.
- Holds a frame-buffer window in inferred single-clock RAM.
- Accepts write bursts and returns read bursts with fixed latency, so the master-side go/done handshakes can be exercised without external SDRAM.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 20, byte-address width presented by the master.
- DEPTH_LOG2, 10, log2 of RAM depth in words.
- BURST_W, 4, burstcount width; maximum burst is 2^(BURST_W-1) beats.
- READ_LATENCY, 2, cycles from read-beat issue to readdatavalid; must be >= 1.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- avs_address  in  ADDR_W  byte address; word index = avs_address[DEPTH_LOG2+1:2], upper bits ignored
- avs_read  in  1  read command
- avs_write  in  1  write command / write beat
- avs_writedata  in  DATA_W  write data
- avs_byteenable  in  DATA_W/8  per-byte write enable
- avs_burstcount  in  BURST_W  beats in burst; sampled on first beat only
- avs_waitrequest  out  1  command/beat not accepted this cycle
- avs_readdata  out  DATA_W  read data
- avs_readdatavalid  out  1  avs_readdata valid this cycle
- busy  out  1  FSM not in IDLE or read pipeline non-empty
- err_sticky  out  1  protocol violation seen; cleared only by reset

Behaviour:
- Reset (reset_n=0 at a clk edge) sets the following:
  - FSM to IDLE, read pipeline flushed, avs_readdatavalid=0, avs_readdata=0, err_sticky=0, busy=0.
  - avs_waitrequest=1 while reset_n=0.
  - RAM contents are not cleared.
- Reset mid-burst aborts the burst. No further beats are written or returned; in-flight read data is discarded.
- FSM states: IDLE, WR_BURST, RD_BURST.
- IDLE:
  - waitrequest=0.
  - avs_write: beat 0 is written at the word index. The base index is latched and remaining = burstcount-1. If remaining>0 the FSM goes to WR_BURST.
  - avs_read: the base index is latched, remaining = burstcount, and the FSM goes to RD_BURST.
  - burstcount=0 is treated as 1.
  - avs_read and avs_write in the same cycle: the write is taken, the read is ignored, and err_sticky is set.
- WR_BURST:
  - waitrequest=0.
  - Each cycle with avs_write=1 writes one beat at base+n and decrements remaining. avs_address is ignored.
  - At remaining=0 the FSM returns to IDLE.
  - avs_write=0 cycles are idle gaps and are legal.
  - avs_read=1 is ignored and sets err_sticky.
- RD_BURST:
  - waitrequest=1.
  - One beat is issued per cycle: the RAM is read at base+n and the data enters a READ_LATENCY-deep valid/data shift pipeline.
  - After the last beat is issued, the FSM returns to IDLE. A new command is accepted the next cycle, overlapping the pipeline drain.
- Latency:
  - Beat k of a read accepted in cycle T appears with readdatavalid in cycle T+1+k+READ_LATENCY-1. For READ_LATENCY=2, beat 0 appears at T+2.
  - Beats are back-to-back with no gaps. The slave never back-pressures returned data.
- Addressing:
  - Word index increments modulo 2^DEPTH_LOG2; a burst crossing the top wraps to word 0.
  - Byte-address bits [1:0] are ignored.
- Byte enables:
  - Only lanes with byteenable=1 are updated. byteenable=0 produces a legal no-op write beat.
- Ordering:
  - Read data is captured at issue. A write accepted after a read is issued never alters that read's returned data.
  - A read accepted after a write beat returns the new data, because the write completes in its accept cycle.

Optional Feature:
- Macro: AVS_RANDOM_WAIT_EN.
- When defined:
  - A 16-bit LFSR (seed 16'hACE1 at reset) forces avs_waitrequest=1 in IDLE and WR_BURST whenever its two LSBs are 2'b00 (~25%).
  - Commands and beats presented during forced waits are not accepted.
  - Used to stress master retry logic.
- When undefined: no LFSR logic; waitrequest is asserted only in reset and RD_BURST.

Decomposition:
- Shared package avmm_pkg holds:
  - the state typedef (IDLE/WR_BURST/RD_BURST);
  - the LFSR seed and tap constants;
  - a function computing the word index from a byte address.
- One natural sub-module: avmm_sp_ram. It is a byte-enabled single-port RAM with a registered read. The remaining READ_LATENCY-1 stages live in the parent.

Test Plan:
- Reset, then a single write of 0xDEADBEEF at addr 0x10 with byteenable 0xF, then a read at 0x10, burstcount 1: readdatavalid fires exactly 2 cycles after read acceptance with data 0xDEADBEEF; busy returns to 0.
- Write burst of 4 beats 0x1..0x4 at addr 0x0 with a 2-cycle avs_write gap after beat 1, then a 4-beat read: 4 consecutive valid beats 0x1,0x2,0x3,0x4; waitrequest=1 for exactly 4 cycles.
- Byte lanes: write 0xFFFFFFFF, then 0x00000000 with byteenable 0x5 at the same address: read returns 0xFF00FF00.
- Wrap: DEPTH_LOG2=10, 3-beat write at byte addr 0xFFC (word 1023) with data A,B,C: words 1023, 0, 1 hold A, B, C, confirmed by single reads.
- Protocol errors: read and write asserted together in IDLE → write performed, no readdatavalid, err_sticky=1. Then reset_n=0 asserted mid 8-beat read after 3 beats issued: no further readdatavalid, err_sticky=0, waitrequest=1 during reset.
- With AVS_RANDOM_WAIT_EN: 1000 random bursts checked against a scoreboard; all data matches and waitrequest is observed high in IDLE at least once.
